// File: rtl/fifo_p2s_serializer.sv
// fifo_p2s_serializer
// Read-domain consumer of the async FIFO. Requests one word at a time from the
// read-side controller and captures it from FIFO read data. It then shifts the
// word out on sout, holding each bit for BIT_DIV clocks, and frames it with
// sout_valid, sof and word_done.
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output.
module fifo_p2s_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_DIV    = 1,
    parameter int RD_LATENCY = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             empty,
    input  logic             rden,
    input  logic [WIDTH-1:0] rdata,
    input  logic             sync_flush,
    output logic             remove,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             word_done,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [1:0]    LAT_INIT = 2'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_SHIFT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic [1:0]       lat_q, lat_d;
    logic             wto_q, wto_d;   // one empty WAIT cycle already seen

    // Advance the shift register by one bit in the configured direction.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Select the bit currently presented on the serial line.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    // State, shift register and counters; async reset abandons any word in flight.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            lat_q   <= 2'd0;
            wto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            lat_q   <= lat_d;
            wto_q   <= wto_d;
        end
    end

    // Next-state logic: request/wait/load handshake, then bit/divider sequencing.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        div_d   = div_q;
        lat_d   = lat_q;
        wto_d   = wto_q;
        if (sync_flush) begin
            // Flush drops any partial word; it is not re-sent.
            state_d = S_IDLE;
            shift_d = '0;
            bit_d   = '0;
            div_d   = '0;
            lat_d   = 2'd0;
            wto_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wto_d = 1'b0;
                    if (!empty) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REQ: begin
                    wto_d   = 1'b0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (rden) begin
                        wto_d = 1'b0;
                        if (RD_LATENCY == 0) begin
                            // Data is valid in the same cycle as rden, so LOAD is skipped.
                            shift_d = rdata;
                            bit_d   = '0;
                            div_d   = '0;
                            state_d = S_SHIFT;
                        end else begin
                            lat_d   = LAT_INIT;
                            state_d = S_LOAD;
                        end
                    end else if (wto_q) begin
                        // Second WAIT cycle without rden: give up, nothing consumed.
                        wto_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        wto_d = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (lat_q == 2'd1) begin
                        shift_d = rdata;
                        bit_d   = '0;
                        div_d   = '0;
                        lat_d   = 2'd0;
                        state_d = S_SHIFT;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            shift_d = '0;
                            state_d = S_IDLE;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shift_d = shift_once(shift_q);
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign remove     = (state_q == S_REQ);
    assign sout_valid = (state_q == S_SHIFT);
    assign sout       = (state_q == S_SHIFT) ? head_bit(shift_q) : 1'b0;
    assign sof        = (state_q == S_SHIFT) && (bit_q == '0);
    assign word_done  = (state_q == S_SHIFT) && (bit_q == BIT_LAST) && (div_q == DIV_LAST);

endmodule

// File: tb/tb_fifo_p2s_serializer.sv
// Bench for fifo_p2s_serializer: a FIFO responder model feeds words and pushes
// expected serial bits to a scoreboard that a negedge monitor compares against.
// A second instance (BIT_DIV=3, LSB first) is driven by a hand-written sequence.
module tb_fifo_p2s_serializer;

    localparam int W = 8;

    logic clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    logic rst, empty, rden, sync_flush;
    logic [W-1:0] rdata;
    logic remove, sout, sout_valid, sof, word_done, busy;

    logic empty_b, rden_b, flush_b;
    logic [W-1:0] rdata_b;
    logic remove_b, sout_b, valid_b, sof_b, done_b, busy_b;

    fifo_p2s_serializer #(.WIDTH(W), .BIT_DIV(1), .RD_LATENCY(1), .MSB_FIRST(1)) u_dut (
        .clk_out(clk_out), .rst(rst), .empty(empty), .rden(rden), .rdata(rdata),
        .sync_flush(sync_flush), .remove(remove), .sout(sout), .sout_valid(sout_valid),
        .sof(sof), .word_done(word_done), .busy(busy)
    );

    fifo_p2s_serializer #(.WIDTH(W), .BIT_DIV(3), .RD_LATENCY(1), .MSB_FIRST(0)) u_dut_b (
        .clk_out(clk_out), .rst(rst), .empty(empty_b), .rden(rden_b), .rdata(rdata_b),
        .sync_flush(flush_b), .remove(remove_b), .sout(sout_b), .sout_valid(valid_b),
        .sof(sof_b), .word_done(done_b), .busy(busy_b)
    );

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_seq;   // exp_seq[W-1] is the first bit on the line
    } vec_t;
    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] fifo_e[$];
    exp_t         sb[$];
    exp_t         e_mon;
    exp_t         e_tmp;

    bit hold_rden   = 1'b0;
    bit force_empty = 1'b0;
    bit pend        = 1'b0;
    bit rd_stage    = 1'b0;
    logic [W-1:0] staged_word = '0;
    logic [W-1:0] staged_exp  = '0;

    int cyc = 0;
    int rden_cyc = 0;
    int last_sof = -1;
    bit spacing_en = 1'b0;
    int done_cnt = 0;
    logic sof_d = 1'b0, remove_d = 1'b0;

    int base, nv, done_at, sofs, idle_bad;
    logic [31:0] pat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w, input logic [W-1:0] e);
        fifo_q.push_back(w);
        fifo_e.push_back(e);
    endtask

    task automatic wait_done(input int target);
        for (int n = 0; n < 200 && done_cnt < target; n++) begin
            @(posedge clk_out); #2;
        end
        check("word_done count", done_cnt, target);
    endtask

    // Cycle counter.
    always @(posedge clk_out) cyc <= cyc + 1;

    // FIFO read-side model: rden the cycle after remove, rdata valid one cycle after rden.
    initial begin
        rden = 1'b0; rdata = '0; empty = 1'b1;
        forever begin
            @(posedge clk_out); #1;
            rden = 1'b0;
            if (rd_stage) begin
                rdata = staged_word;
                rd_stage = 1'b0;
            end else begin
                rdata = ~staged_word;
            end
            if (pend) begin
                pend = 1'b0;
                if (!hold_rden && fifo_q.size() > 0) begin
                    staged_word = fifo_q.pop_front();
                    staged_exp  = fifo_e.pop_front();
                    for (int i = 0; i < W; i++) begin
                        e_tmp.b = staged_exp[W-1-i];
                        e_tmp.s = (i == 0);
                        e_tmp.d = (i == W-1);
                        sb.push_back(e_tmp);
                    end
                    rden = 1'b1;
                    rdata = ~staged_word;
                    rd_stage = 1'b1;
                    rden_cyc = cyc;
                end
            end
            if (remove) pend = 1'b1;
            empty = (fifo_q.size() == 0) || force_empty;
        end
    end

    // Output monitor: scoreboard compare, idle-line, remove width, latency and spacing.
    always @(negedge clk_out) begin
        if (sout_valid) begin
            if (sb.size() == 0) begin
                check("unexpected sout_valid", {31'd0, sout_valid}, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("sout bit", {31'd0, sout}, {31'd0, e_mon.b});
                check("sof", {31'd0, sof}, {31'd0, e_mon.s});
                check("word_done", {31'd0, word_done}, {31'd0, e_mon.d});
            end
        end else begin
            check("idle line", {29'd0, sout, sof, word_done}, 32'd0);
        end
        check("remove single-cycle", {31'd0, remove && remove_d}, 32'd0);
        if (sof && !sof_d) begin
            check("first bit latency", cyc - rden_cyc, 2);
            if (spacing_en && last_sof >= 0) check("frame spacing", cyc - last_sof, 12);
            last_sof = cyc;
        end
        if (word_done) done_cnt++;
        sof_d = sof;
        remove_d = remove;
    end

    vec_t vecs [5];

    // Main test sequence.
    initial begin
        vecs[0] = '{word: 8'hA5, exp_seq: 8'b1010_0101};
        vecs[1] = '{word: 8'h3C, exp_seq: 8'b0011_1100};
        vecs[2] = '{word: 8'h80, exp_seq: 8'b1000_0000};
        vecs[3] = '{word: 8'h01, exp_seq: 8'b0000_0001};
        vecs[4] = '{word: 8'h6E, exp_seq: 8'b0110_1110};

        rst = 1'b1; sync_flush = 1'b0;
        empty_b = 1'b1; rden_b = 1'b0; rdata_b = '0; flush_b = 1'b0;
        repeat (2) @(posedge clk_out);
        #2;
        check("reset outputs", {26'd0, remove, sout, sout_valid, sof, word_done, busy}, 32'd0);
        check("reset outputs b", {26'd0, remove_b, sout_b, valid_b, sof_b, done_b, busy_b}, 32'd0);
        rst = 1'b0;
        @(posedge clk_out); #2;
        check("idle after reset", {31'd0, busy}, 32'd0);

        // Single words from the table, one frame at a time.
        for (int i = 0; i < 5; i++) begin
            base = done_cnt;
            push_word(vecs[i].word, vecs[i].exp_seq);
            wait_done(base + 1);
            repeat (3) @(posedge clk_out);
            #2;
        end

        // Three words back to back: frame starts 12 cycles apart.
        base = done_cnt;
        spacing_en = 1'b1; last_sof = -1;
        for (int i = 0; i < 3; i++) push_word(vecs[i].word, vecs[i].exp_seq);
        wait_done(base + 3);
        spacing_en = 1'b0;

        // remove without rden, empty rises: two WAIT cycles then IDLE, no re-request.
        base = done_cnt;
        hold_rden = 1'b1;
        push_word(8'h5A, 8'h5A);
        for (int n = 0; n < 20 && !remove; n++) begin
            @(posedge clk_out); #2;
        end
        check("timeout remove seen", {31'd0, remove}, 32'd1);
        force_empty = 1'b1;
        @(posedge clk_out); #2;
        check("timeout wait1 busy", {30'd0, busy, remove}, 32'd2);
        @(posedge clk_out); #2;
        check("timeout wait2 busy", {30'd0, busy, remove}, 32'd2);
        @(posedge clk_out); #2;
        check("timeout back to idle", {31'd0, busy}, 32'd0);
        for (int n = 0; n < 8; n++) begin
            @(posedge clk_out); #2;
            check("no re-request while empty", {30'd0, remove, sout_valid}, 32'd0);
        end
        force_empty = 1'b0; hold_rden = 1'b0;
        wait_done(base + 1);

        // One-cycle flush at bit 3, then flush held high keeps IDLE.
        base = done_cnt;
        push_word(8'h3C, 8'h3C);
        for (int n = 0; n < 40 && !sof; n++) begin
            @(posedge clk_out); #2;
        end
        check("flush frame started", {31'd0, sof}, 32'd1);
        repeat (3) begin
            @(posedge clk_out); #2;
        end
        sync_flush = 1'b1;
        @(negedge clk_out); #1;
        sb.delete();
        @(posedge clk_out); #2;
        sync_flush = 1'b0;
        check("flush outputs", {27'd0, sout_valid, sof, word_done, remove, busy}, 32'd0);
        repeat (6) @(posedge clk_out);
        #2;
        check("flush no word_done", done_cnt, base);
        sync_flush = 1'b1;
        push_word(8'h96, 8'h96);
        repeat (5) begin
            @(posedge clk_out); #2;
            check("flush holds idle", {30'd0, busy, remove}, 32'd0);
        end
        sync_flush = 1'b0;
        wait_done(base + 1);

        // Async reset between edges mid-SHIFT.
        push_word(8'hC6, 8'hC6);
        for (int n = 0; n < 40 && !sof; n++) begin
            @(posedge clk_out); #2;
        end
        check("reset frame started", {31'd0, sof}, 32'd1);
        repeat (3) begin
            @(posedge clk_out); #2;
        end
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async reset outputs", {26'd0, remove, sout, sout_valid, sof, word_done, busy}, 32'd0);
        @(posedge clk_out); #3;
        rst = 1'b0;
        @(posedge clk_out); #2;
        check("idle after mid-frame reset", {30'd0, busy, sout_valid}, 32'd0);

        // Second instance: BIT_DIV=3, LSB first, word 8'h01.
        empty_b = 1'b0;
        for (int n = 0; n < 20 && !remove_b; n++) begin
            @(posedge clk_out); #2;
        end
        check("b remove", {31'd0, remove_b}, 32'd1);
        empty_b = 1'b1;
        @(posedge clk_out); #2;
        rden_b = 1'b1; rdata_b = 8'hFE;
        @(posedge clk_out); #2;
        rden_b = 1'b0; rdata_b = 8'h01;
        @(posedge clk_out); #2;
        rdata_b = 8'hFE;
        check("b first bit latency", {31'd0, valid_b}, 32'd1);
        nv = 0; pat = '0; done_at = 0; sofs = 0; idle_bad = 0;
        for (int n = 0; n < 30; n++) begin
            if (valid_b) begin
                if (nv < 32) pat[nv] = sout_b;
                nv++;
                if (sof_b) sofs++;
                if (done_b) done_at = nv;
            end else if (sout_b || sof_b || done_b) begin
                idle_bad++;
            end
            @(posedge clk_out); #2;
        end
        check("b valid cycles", nv, 24);
        check("b bit pattern", pat, 32'h0000_0007);
        check("b word_done position", done_at, 24);
        check("b sof cycles", sofs, 3);
        check("b idle line", idle_bad, 0);
        check("b idle at end", {31'd0, busy_b}, 32'd0);

        check("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
